pipe_fwd_scoreboard: RTL

- Parametrised hazard/forwarding unit for the ID stage of the pipelined CPU.
- Tracks in-flight register writers across DEPTH post-ID stages in a shifting scoreboard.
- Per-writer result latency, so loads and longer-latency units produce correct multi-cycle stalls.
- Produces per-source forwarding selects for rs and rt independently; sits beside the ID control decoder, which supplies the decoded fields.

---
 rtl/pipe_fwd_scoreboard_if.sv | 31 +++
 rtl/pipe_fwd_scoreboard.sv | 101 ++++++++++
 2 files changed

// File: rtl/pipe_fwd_scoreboard_if.sv
// rtl/pipe_fwd_scoreboard_if.sv - ID-stage decode fields in, forwarding selects and issue/stall out
interface pipe_fwd_scoreboard_if #(
    parameter int NRB   = 5,
    parameter int DEPTH = 3,
    parameter int FW    = $clog2(DEPTH + 1)
);
    logic             hold;
    logic             id_valid;
    logic             id_wreg;
    logic [NRB-1:0]   id_rn;
    logic             id_m2reg;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [NRB-1:0]   rs;
    logic [NRB-1:0]   rt;
    logic [FW-1:0]    fwda;
    logic [FW-1:0]    fwdb;
    logic             stall;
    logic             issue;
    logic [DEPTH-1:0] sb_valid;

    modport master (
        output hold, id_valid, id_wreg, id_rn, id_m2reg, id_use_rs, id_use_rt, rs, rt,
        input  fwda, fwdb, stall, issue, sb_valid
    );

    modport slave (
        input  hold, id_valid, id_wreg, id_rn, id_m2reg, id_use_rs, id_use_rt, rs, rt,
        output fwda, fwdb, stall, issue, sb_valid
    );
endinterface

// File: rtl/pipe_fwd_scoreboard.sv
// rtl/pipe_fwd_scoreboard.sv - shifting writer scoreboard with per-source forwarding and load-use stall
// Optional PIPE_FWD_SB_PERF_EN adds saturating stall_cycles and fwd_count outputs.
module pipe_fwd_scoreboard #(
    parameter int NRB      = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FW       = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
`ifdef PIPE_FWD_SB_PERF_EN
    output logic [31:0]         stall_cycles,
    output logic [31:0]         fwd_count,
`endif
    pipe_fwd_scoreboard_if.slave bus
);
    localparam logic [FW-1:0] LAT_LOAD = FW'(LOAD_LAT);

    logic [DEPTH-1:0] v;
    logic [NRB-1:0]   rn  [DEPTH];
    logic [FW-1:0]    lat [DEPTH];

    logic          haz_a;
    logic          haz_b;
    logic [FW-1:0] sel_a;
    logic [FW-1:0] sel_b;
    logic          stall_c;
    logic          issue_c;

    // Walk oldest to youngest so the youngest match overrides any older one.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (bus.id_use_rs && v[k] && (rn[k] == bus.rs) && (bus.rs != '0)) begin
                if (k >= int'(lat[k])) begin
                    sel_a = FW'(k + 1);
                    haz_a = 1'b0;
                end else begin
                    sel_a = '0;
                    haz_a = 1'b1;
                end
            end
            if (bus.id_use_rt && v[k] && (rn[k] == bus.rt) && (bus.rt != '0)) begin
                if (k >= int'(lat[k])) begin
                    sel_b = FW'(k + 1);
                    haz_b = 1'b0;
                end else begin
                    sel_b = '0;
                    haz_b = 1'b1;
                end
            end
        end
    end

    assign stall_c      = bus.id_valid & (haz_a | haz_b);
    assign issue_c      = bus.id_valid & ~stall_c & ~bus.hold;
    assign bus.stall    = stall_c;
    assign bus.issue    = issue_c;
    assign bus.fwda     = sel_a;
    assign bus.fwdb     = sel_b;
    assign bus.sb_valid = v;

    always_ff @(posedge clock) begin
        if (reset) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rn[k]  <= '0;
                lat[k] <= '0;
            end
        end else if (!bus.hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                v[k]   <= v[k-1];
                rn[k]  <= rn[k-1];
                lat[k] <= lat[k-1];
            end
            // A stalled or idle ID slot enters as a bubble because issue is low.
            v[0]   <= issue_c & bus.id_wreg & (bus.id_rn != '0);
            rn[0]  <= bus.id_rn;
            lat[0] <= bus.id_m2reg ? LAT_LOAD : '0;
        end
    end

`ifdef PIPE_FWD_SB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
            fwd_count    <= '0;
        end else if (!bus.hold) begin
            if (stall_c && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (issue_c && ((sel_a != '0) || (sel_b != '0)) && (fwd_count != '1)) begin
                fwd_count <= fwd_count + 32'd1;
            end
        end
    end
`endif
endmodule
